// File: rtl/crc32_fcs_ctrl.sv
// crc32_fcs_ctrl: frame sequencer around a byte-serial CRC32 engine.
// Passes payload through, optionally zero-pads to MIN_LEN, appends the
// 4-byte FCS (low byte first) and drives the engine clear/update strobes.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_data/s_valid/s_last/s_ready  payload input stream
//   m_data/m_valid/m_last/m_ready  output stream (payload, pad, FCS)
//   crc_data/crc_valid/crc_clr     engine controls; crc_value engine result
//   busy, frame_done, frame_cnt    frame status
module crc32_fcs_ctrl #(
    parameter int MIN_LEN = 60,
    parameter bit PAD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [7:0]  crc_data,
    output logic        crc_valid,
    output logic        crc_clr,
    input  logic [31:0] crc_value,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    typedef enum logic [2:0] {S_CLR, S_IDLE, S_DATA, S_PAD, S_FCS} state_t;
    localparam logic [15:0] MIN = 16'(MIN_LEN);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_n;
    logic [1:0]  k_q, k_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    // byte count after the current accepted byte, saturating
    assign cnt_n = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        m_data       = 8'h00;
        m_last       = 1'b0;
        crc_valid    = 1'b0;
        crc_clr      = 1'b0;
        case (state_q)
            S_CLR: begin
                crc_clr = 1'b1;
                cnt_d   = 16'd0;
                k_d     = 2'd0;
                state_d = S_IDLE;
            end
            S_IDLE, S_DATA: begin
                m_data    = s_data;
                m_valid   = s_valid;
                s_ready   = m_ready;
                crc_valid = s_valid && m_ready;
                if (crc_valid) begin
                    cnt_d   = cnt_n;
                    state_d = !s_last ? S_DATA : (PAD_EN && cnt_n < MIN) ? S_PAD : S_FCS;
                end
            end
            S_PAD: begin
                m_valid   = 1'b1;
                crc_valid = m_ready;
                if (m_ready) begin
                    cnt_d   = cnt_n;
                    state_d = (cnt_n == MIN) ? S_FCS : S_PAD;
                end
            end
            S_FCS: begin
                m_valid = 1'b1;
                m_data  = crc_value[{k_q, 3'b000} +: 8];
                m_last  = (k_q == 2'd3);
                if (m_ready) begin
                    k_d = k_q + 2'd1;
                    if (m_last) begin
                        state_d      = S_CLR;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_CLR;
        endcase
        // reset silences the output and clears the engine in the same cycle
        if (!rst_n) begin
            s_ready   = 1'b0;
            m_valid   = 1'b0;
            crc_valid = 1'b0;
            crc_clr   = 1'b1;
        end
        busy_d = (state_d == S_DATA) || (state_d == S_PAD) || (state_d == S_FCS);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_CLR;
            cnt_q        <= 16'd0;
            k_q          <= 2'd0;
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end
    assign crc_data   = m_data;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_crc32_fcs_ctrl.sv
// tb_crc32_fcs_ctrl: directed bench for crc32_fcs_ctrl with a CRC32 engine model.
module tb_crc32_fcs_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data[2], m_data[2], crc_data[2];
    logic        s_valid[2], s_last[2], s_ready[2], m_valid[2], m_last[2], m_ready[2];
    logic        crc_valid[2], crc_clr[2], busy[2], frame_done[2];
    logic [31:0] crc_value[2], crc_r[2];
    logic [15:0] frame_cnt[2];
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  out_q[$], exp_q[$], base_q[$];
    int          last_idx, first_acc, cycles, stall_bad, srdy_bad, ctl_bad;
    logic        timeout_f, fd_after, gap_rdy, busy_after, busy_last;
    logic [15:0] cnt_after;

    always #5 clk = ~clk;

    crc32_fcs_ctrl #(.MIN_LEN(60), .PAD_EN(1'b0)) u_nopad (
        .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
        .m_ready(m_ready[0]), .crc_data(crc_data[0]), .crc_valid(crc_valid[0]), .crc_clr(crc_clr[0]),
        .crc_value(crc_value[0]), .busy(busy[0]), .frame_done(frame_done[0]), .frame_cnt(frame_cnt[0]));
    crc32_fcs_ctrl #(.MIN_LEN(60), .PAD_EN(1'b1)) u_pad (
        .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
        .m_ready(m_ready[1]), .crc_data(crc_data[1]), .crc_valid(crc_valid[1]), .crc_clr(crc_clr[1]),
        .crc_value(crc_value[1]), .busy(busy[1]), .frame_done(frame_done[1]), .frame_cnt(frame_cnt[1]));

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[j]) c = crc_upd(c, q[j]);
        return ~c;
    endfunction

    // byte-serial engine model: registered, result valid the cycle after the last update
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (crc_clr[d]) crc_r[d] <= 32'hFFFFFFFF;
            else if (crc_valid[d]) crc_r[d] <= crc_upd(crc_r[d], crc_data[d]);
        end
    end
    assign crc_value[0] = ~crc_r[0];
    assign crc_value[1] = ~crc_r[1];

    task automatic run_frame(input int d, input logic [7:0] pay[$], input int stall_pct, input int abort_at);
        int   i;
        bit   done, hold;
        logic [7:0] hold_d;
        i = 0; done = 0; hold = 0; hold_d = 8'h00;
        out_q.delete();
        last_idx = -1; first_acc = -1; cycles = 0; stall_bad = 0; srdy_bad = 0; ctl_bad = 0; busy_last = 0;
        while (!done && cycles < 3000 && !(abort_at >= 0 && i >= abort_at)) begin
            @(negedge clk);
            s_valid[d] = (i < pay.size());
            s_last[d]  = (i == pay.size() - 1);
            if (i < pay.size()) s_data[d] = pay[i];
            else s_data[d] = 8'h00;
            m_ready[d] = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            #1;
            if (hold && (m_valid[d] !== 1'b1 || m_data[d] !== hold_d)) stall_bad++;
            hold = m_valid[d] && !m_ready[d];
            hold_d = m_data[d];
            if (i >= pay.size() && s_ready[d]) srdy_bad++;
            if ((crc_clr[d] && crc_valid[d]) || crc_data[d] !== m_data[d] || frame_done[d]) ctl_bad++;
            if (s_valid[d] && s_ready[d]) begin
                if (first_acc < 0) first_acc = cycles;
                i++;
            end
            if (m_valid[d] && m_ready[d]) begin
                out_q.push_back(m_data[d]);
                if (m_last[d]) begin
                    done = 1;
                    last_idx = out_q.size() - 1;
                    busy_last = busy[d];
                end
            end
            cycles++;
        end
        timeout_f = !done && abort_at < 0;
        if (abort_at >= 0) return;
        @(negedge clk);
        s_valid[d] = 0; s_last[d] = 0; m_ready[d] = 1;
        #1;
        fd_after = frame_done[d]; gap_rdy = s_ready[d]; busy_after = busy[d]; cnt_after = frame_cnt[d];
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++; if (m_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid[%0d] got %b want 0", d, m_valid[d]); end
            n_chk++; if (crc_clr[d] !== 1'b1) begin n_fail++; $display("FAIL reset_crc_clr[%0d] got %b want 1", d, crc_clr[d]); end
            n_chk++; if (s_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready[%0d] got %b want 0", d, s_ready[d]); end
            n_chk++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy[d]); end
            n_chk++; if (frame_done[d] !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done[%0d] got %b want 0", d, frame_done[d]); end
            n_chk++; if (frame_cnt[d] !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt[%0d] got %0d want 0", d, frame_cnt[d]); end
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_chk++; if (crc_clr[1] !== 1'b1) begin n_fail++; $display("FAIL release_crc_clr got %b want 1", crc_clr[1]); end
        n_chk++; if (s_ready[1] !== 1'b0) begin n_fail++; $display("FAIL release_s_ready got %b want 0", s_ready[1]); end
        @(negedge clk);
        #1;
        n_chk++; if (crc_clr[1] !== 1'b0) begin n_fail++; $display("FAIL idle_crc_clr got %b want 0", crc_clr[1]); end
        n_chk++; if (s_ready[1] !== 1'b1) begin n_fail++; $display("FAIL idle_s_ready got %b want 1", s_ready[1]); end
    endtask

    task automatic test_basic();
        logic [7:0] pay[$];
        for (int b = 0; b < 9; b++) pay.push_back(8'(8'h31 + b));
        exp_q = pay;
        exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        run_frame(0, pay, 0, -1);
        n_chk++; if (timeout_f !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", timeout_f); end
        n_chk++; if (out_q.size() !== 13) begin n_fail++; $display("FAIL basic_len got %0d want 13", out_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            n_chk++;
            if (j >= out_q.size() || out_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL basic_byte[%0d] got %h want %h", j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_q[j]); end
        end
        n_chk++; if (last_idx !== 12) begin n_fail++; $display("FAIL basic_m_last_pos got %0d want 12", last_idx); end
        n_chk++; if (cycles !== 13) begin n_fail++; $display("FAIL basic_cycles got %0d want 13", cycles); end
        n_chk++; if (fd_after !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done got %b want 1", fd_after); end
        n_chk++; if (cnt_after !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt got %0d want 1", cnt_after); end
        n_chk++; if (busy_last !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_fcs got %b want 1", busy_last); end
        n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
        n_chk++; if (gap_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clr_s_ready got %b want 0", gap_rdy); end
        n_chk++; if (srdy_bad !== 0) begin n_fail++; $display("FAIL basic_s_ready_in_fcs got %0d want 0", srdy_bad); end
        n_chk++; if (ctl_bad !== 0) begin n_fail++; $display("FAIL basic_ctl got %0d want 0", ctl_bad); end
    endtask

    task automatic test_pad();
        logic [7:0] pay[$];
        logic [31:0] c;
        for (int b = 0; b < 9; b++) pay.push_back(8'(8'h31 + b));
        exp_q = pay;
        for (int b = 0; b < 51; b++) exp_q.push_back(8'h00);
        c = ref_crc(exp_q);
        exp_q.push_back(c[7:0]); exp_q.push_back(c[15:8]); exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
        run_frame(1, pay, 0, -1);
        base_q = out_q;
        n_chk++; if (out_q.size() !== 64) begin n_fail++; $display("FAIL pad_len got %0d want 64", out_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            n_chk++;
            if (j >= out_q.size() || out_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL pad_byte[%0d] got %h want %h", j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_q[j]); end
        end
        n_chk++; if (cycles !== 64) begin n_fail++; $display("FAIL pad_cycles got %0d want 64", cycles); end
        n_chk++; if (srdy_bad !== 0) begin n_fail++; $display("FAIL pad_s_ready got %0d want 0", srdy_bad); end
        n_chk++; if (ctl_bad !== 0) begin n_fail++; $display("FAIL pad_ctl got %0d want 0", ctl_bad); end
        n_chk++; if (cnt_after !== 16'd1) begin n_fail++; $display("FAIL pad_frame_cnt got %0d want 1", cnt_after); end
    endtask

    task automatic test_no_pad();
        logic [7:0] pay[$];
        logic [31:0] c;
        for (int n = 60; n <= 61; n++) begin
            pay.delete();
            for (int b = 0; b < n; b++) pay.push_back(8'(b * 7 + 3));
            exp_q = pay;
            c = ref_crc(pay);
            exp_q.push_back(c[7:0]); exp_q.push_back(c[15:8]); exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
            run_frame(1, pay, 0, -1);
            n_chk++; if (out_q.size() !== n + 4) begin n_fail++; $display("FAIL nopad%0d_len got %0d want %0d", n, out_q.size(), n + 4); end
            for (int j = 0; j < exp_q.size(); j++) begin
                n_chk++;
                if (j >= out_q.size() || out_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL nopad%0d_byte[%0d] got %h want %h", n, j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_q[j]); end
            end
            n_chk++; if (cycles !== n + 4) begin n_fail++; $display("FAIL nopad%0d_cycles got %0d want %0d", n, cycles, n + 4); end
            n_chk++; if (last_idx !== n + 3) begin n_fail++; $display("FAIL nopad%0d_m_last_pos got %0d want %0d", n, last_idx, n + 3); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] pay[$];
        for (int b = 0; b < 9; b++) pay.push_back(8'(8'h31 + b));
        run_frame(1, pay, 50, -1);
        n_chk++; if (timeout_f !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b want 0", timeout_f); end
        n_chk++; if (out_q.size() !== base_q.size()) begin n_fail++; $display("FAIL stall_len got %0d want %0d", out_q.size(), base_q.size()); end
        for (int j = 0; j < base_q.size(); j++) begin
            n_chk++;
            if (j >= out_q.size() || out_q[j] !== base_q[j]) begin n_fail++; $display("FAIL stall_byte[%0d] got %h want %h", j, (j < out_q.size()) ? out_q[j] : 8'hxx, base_q[j]); end
        end
        n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_hold got %0d want 0", stall_bad); end
        n_chk++; if (srdy_bad !== 0) begin n_fail++; $display("FAIL stall_s_ready got %0d want 0", srdy_bad); end
        n_chk++; if (ctl_bad !== 0) begin n_fail++; $display("FAIL stall_ctl got %0d want 0", ctl_bad); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pay[$];
        pay.push_back(8'h00);
        exp_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'h8D); exp_q.push_back(8'hEF); exp_q.push_back(8'h02); exp_q.push_back(8'hD2);
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        for (int f = 1; f <= 3; f++) begin
            run_frame(0, pay, 0, -1);
            n_chk++; if (out_q.size() !== 5) begin n_fail++; $display("FAIL b2b%0d_len got %0d want 5", f, out_q.size()); end
            for (int j = 0; j < 5; j++) begin
                n_chk++;
                if (j >= out_q.size() || out_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL b2b%0d_byte[%0d] got %h want %h", f, j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_q[j]); end
            end
            n_chk++; if (gap_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_gap_s_ready got %b want 0", f, gap_rdy); end
            n_chk++; if (first_acc !== 0) begin n_fail++; $display("FAIL b2b%0d_first_accept got %0d want 0", f, first_acc); end
            n_chk++; if (cnt_after !== 16'(f)) begin n_fail++; $display("FAIL b2b%0d_frame_cnt got %0d want %0d", f, cnt_after, f); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pay[$];
        for (int b = 0; b < 20; b++) pay.push_back(8'(8'hA0 + b));
        run_frame(0, pay, 0, 4);
        @(negedge clk);
        rst_n = 0; s_data[0] = pay[4]; s_valid[0] = 1; s_last[0] = 0; m_ready[0] = 1;
        #1;
        n_chk++; if (m_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid got %b want 0", m_valid[0]); end
        n_chk++; if (crc_clr[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_crc_clr got %b want 1", crc_clr[0]); end
        n_chk++; if (crc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_crc_valid got %b want 0", crc_valid[0]); end
        @(negedge clk);
        #1;
        n_chk++; if (frame_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt[0]); end
        n_chk++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy[0]); end
        @(negedge clk);
        rst_n = 1; s_valid[0] = 0;
        #1;
        n_chk++; if (crc_clr[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_release_crc_clr got %b want 1", crc_clr[0]); end
        pay.delete();
        for (int b = 0; b < 9; b++) pay.push_back(8'(8'h31 + b));
        exp_q = pay;
        exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        run_frame(0, pay, 0, -1);
        n_chk++; if (out_q.size() !== 13) begin n_fail++; $display("FAIL midrst_len got %0d want 13", out_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            n_chk++;
            if (j >= out_q.size() || out_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL midrst_byte[%0d] got %h want %h", j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_q[j]); end
        end
        n_chk++; if (cnt_after !== 16'd1) begin n_fail++; $display("FAIL midrst_frame_cnt_after got %0d want 1", cnt_after); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_data[d] = 8'h00; s_valid[d] = 0; s_last[d] = 0; m_ready[d] = 1;
        end
        test_reset();
        test_basic();
        test_pad();
        test_no_pad();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "simulation time limit reached");
    end
endmodule
